alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter fronting one shared registered ALU for two requesters, one operation in flight.
// Optional feature macro ALU_ARBITER_ZERO_FLAG_EN adds rsp0_zero/rsp1_zero (result-is-zero, qualified by valid).
module alu_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_data,
  output logic         rsp0_cout,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_data,
  output logic         rsp1_cout,
`ifdef ALU_ARBITER_ZERO_FLAG_EN
  output logic         rsp0_zero,
  output logic         rsp1_zero,
`endif
  output logic [2:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  input  logic [N-1:0] alu_result,
  input  logic         alu_cout
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
  } op_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state_q, state_d;
  op_t          lat_q;
  op_t          req0_pl, req1_pl;
  logic         grant_q, grant_c;
  logic         last_q;
  logic         accept_c, rsp_hs_c;
  logic [1:0]   rsp_valid_q;
  logic [1:0]   rsp_cout_q;
  logic [N-1:0] rsp_data_q [2];
  logic [N-1:0] res_data_c;
  logic         res_cout_c;

  assign req0_pl = '{op: req0_op, a: req0_a, b: req0_b, cin: req0_cin};
  assign req1_pl = '{op: req1_op, a: req1_a, b: req1_b, cin: req1_cin};

  // On a tie the requester not served last wins; a lone requester wins outright.
  assign grant_c  = (req0_valid && req1_valid) ? !last_q : req1_valid;
  assign accept_c = (state_q == IDLE) && (req0_valid || req1_valid);
  assign rsp_hs_c = (state_q == RESP) &&
                    ((rsp_valid_q[0] && rsp0_ready) || (rsp_valid_q[1] && rsp1_ready));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accept handshake; gated by rst_n so nothing is offered while reset is held
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      req0_ready = req0_valid && !grant_c;
      req1_ready = req1_valid && grant_c;
    end
  end

  // Response shaping: mov bypasses the ALU, slt returns the compare flag as the data word
  always_comb begin
    res_data_c = alu_result;
    res_cout_c = 1'b0;
    case (lat_q.op)
      OP_MOV:         res_data_c = lat_q.a;
      OP_SLT: begin
        res_data_c = N'(alu_cout);
        res_cout_c = alu_cout;
      end
      OP_ADD, OP_SUB: res_cout_c = alu_cout;
      default:        res_cout_c = 1'b0;
    endcase
  end

  // Operand latch (drives alu_*) and per-requester response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= '0;
      rsp_cout_q  <= '0;
      rsp_data_q  <= '{default: '0};
    end else begin
      if (accept_c) begin
        grant_q <= grant_c;
        lat_q   <= grant_c ? req1_pl : req0_pl;
      end
      if (state_q == WAIT) begin
        rsp_valid_q[grant_q] <= 1'b1;
        rsp_data_q[grant_q]  <= res_data_c;
        rsp_cout_q[grant_q]  <= res_cout_c;
      end
      if (rsp_hs_c) begin
        last_q      <= grant_q;
        rsp_valid_q <= '0;
        rsp_cout_q  <= '0;
        rsp_data_q  <= '{default: '0};
      end
    end
  end

`ifdef ALU_ARBITER_ZERO_FLAG_EN
  logic [1:0] rsp_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero_q <= '0;
    end else begin
      if (state_q == WAIT) rsp_zero_q[grant_q] <= (res_data_c == '0);
      if (rsp_hs_c)        rsp_zero_q <= '0;
    end
  end

  assign rsp0_zero = rsp_zero_q[0];
  assign rsp1_zero = rsp_zero_q[1];
`endif

  assign alu_op     = lat_q.op;
  assign alu_a      = lat_q.a;
  assign alu_b      = lat_q.b;
  assign alu_cin    = lat_q.cin;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp0_cout  = rsp_cout_q[0];
  assign rsp1_cout  = rsp_cout_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural registered ALU.
// Builds with or without ALU_ARBITER_ZERO_FLAG_EN.
module tb_alu_arbiter;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [2:0]   req0_op;
  logic [N-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [2:0]   req1_op;
  logic [N-1:0] req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp0_cout;
  logic [N-1:0] rsp0_data;
  logic         rsp1_valid, rsp1_ready, rsp1_cout;
  logic [N-1:0] rsp1_data;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
  logic         rsp0_zero, rsp1_zero;
`endif
  logic [2:0]   alu_op;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic         alu_cin, alu_cout;

  logic         force_en;
  logic [N-1:0] force_val;
  logic [N:0]   m_sum;
  logic [N-1:0] m_res;
  logic         m_c;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout),
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
`endif
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // Behavioural ALU; logic ops and mov report cout=1 and mov returns b, so the arbiter must mask them
  always_comb begin
    m_sum = '0;
    m_res = '0;
    m_c   = 1'b1;
    case (alu_op)
      3'b000: m_res = alu_b;
      3'b001: m_res = ~alu_a;
      3'b010: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
        m_res = m_sum[N-1:0];
        m_c   = m_sum[N];
      end
      3'b011: m_res = ~(alu_a | alu_b);
      3'b100: begin
        m_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, alu_cin};
        m_res = m_sum[N-1:0];
        m_c   = m_sum[N];
      end
      3'b101: m_res = ~(alu_a & alu_b);
      3'b110: m_res = alu_a & alu_b;
      default: begin
        m_res = 32'hAAAA5555;
        m_c   = $signed(alu_a) < $signed(alu_b);
      end
    endcase
    if (force_en) m_res = force_val;
  end

  always @(posedge clk) begin
    alu_result <= m_res;
    alu_cout   <= m_c;
  end

  task automatic clear_inputs();
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; req1_cin = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_req(input bit k, input logic [2:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic cin);
    if (k) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; end
    else   begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; end
  endtask

  // Drives one transaction end-to-end and reports what was observed; callers do the comparisons
  task automatic run_op(input bit k, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic cin,
                        output logic [N-1:0] data, output logic cout, output int lat,
                        output logic other_busy, output logic zero);
    int n;
    data = '0; cout = 0; lat = 0; other_busy = 0; zero = 0;
    drive_req(k, op, a, b, cin);
    #1;
    n = 0;
    while (!(k ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    if (k) req1_valid = 0; else req0_valid = 0;
    lat = 1;
    while (!(k ? rsp1_valid : rsp0_valid) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    data       = k ? rsp1_data : rsp0_data;
    cout       = k ? rsp1_cout : rsp0_cout;
    other_busy = k ? (rsp0_valid | (|rsp0_data) | rsp0_cout)
                   : (rsp1_valid | (|rsp1_data) | rsp1_cout);
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    zero = k ? rsp1_zero : rsp0_zero;
`endif
    if (k) rsp1_ready = 1; else rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req0_valid = 1; req1_valid = 1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout} !== 4'b0) begin
      miscompares++; $display("FAIL reset_rsp_flags: got %b want 0000", {rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout});
    end
    vectors++;
    if ((rsp0_data | rsp1_data) !== '0) begin
      miscompares++; $display("FAIL reset_rsp_data: got %h/%h want 0", rsp0_data, rsp1_data);
    end
    vectors++;
    if ({alu_op, alu_a, alu_b, alu_cin} !== '0) begin
      miscompares++; $display("FAIL reset_alu: got op=%b a=%h b=%h cin=%b want 0", alu_op, alu_a, alu_b, alu_cin);
    end
    @(posedge clk); #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready_held: got %b want 00", {req0_ready, req1_ready});
    end
    apply_reset();
  endtask

  task automatic test_add();
    logic [N-1:0] d; logic c, ob, z; int lat;
    run_op(0, 3'b010, 32'hFFFFFFFF, 32'h1, 0, d, c, lat, ob, z);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL add_data: got %h want 00000000", d); end
    vectors++;
    if (c !== 1'b1) begin miscompares++; $display("FAIL add_cout: got %b want 1", c); end
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL add_latency: got %0d want 3", lat); end
    vectors++;
    if (ob !== 1'b0) begin miscompares++; $display("FAIL add_rsp1_idle: got %b want 0", ob); end
  endtask

  task automatic test_mov();
    logic [N-1:0] d; logic c, ob, z; int lat;
    force_en = 1; force_val = 32'hDEADBEEF;
    run_op(1, 3'b000, 32'h12345678, 32'h0BADF00D, 1, d, c, lat, ob, z);
    force_en = 0;
    vectors++;
    if (d !== 32'h12345678) begin miscompares++; $display("FAIL mov_data: got %h want 12345678", d); end
    vectors++;
    if (c !== 1'b0) begin miscompares++; $display("FAIL mov_cout: got %b want 0", c); end
    vectors++;
    if (ob !== 1'b0) begin miscompares++; $display("FAIL mov_rsp0_idle: got %b want 0", ob); end
  endtask

  task automatic test_slt();
    logic [N-1:0] d; logic c, ob, z; int lat;
    run_op(0, 3'b111, 32'd3, 32'd7, 0, d, c, lat, ob, z);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL slt_lt_data: got %h want 00000001", d); end
    vectors++;
    if (c !== 1'b1) begin miscompares++; $display("FAIL slt_lt_cout: got %b want 1", c); end
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    vectors++;
    if (z !== 1'b0) begin miscompares++; $display("FAIL slt_lt_zero: got %b want 0", z); end
`endif
    run_op(1, 3'b111, 32'd7, 32'd3, 0, d, c, lat, ob, z);
    vectors++;
    if ({d, c} !== {32'h0, 1'b0}) begin miscompares++; $display("FAIL slt_ge: got %h/%b want 00000000/0", d, c); end
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    vectors++;
    if (z !== 1'b1) begin miscompares++; $display("FAIL slt_ge_zero: got %b want 1", z); end
`endif
  endtask

  task automatic test_ops();
    logic [2:0]   ops [5] = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [N-1:0] as  [5] = '{32'h0000FFFF, 32'hF0F0F0F0, 32'd5, 32'hFF00FF00, 32'hFF00FF00};
    logic [N-1:0] bs  [5] = '{32'h0, 32'h0F0F0000, 32'd3, 32'h0FF00FF0, 32'h0FF00FF0};
    logic         cs  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [N-1:0] ed  [5] = '{32'hFFFF0000, 32'h00000F0F, 32'h2, 32'hF0FFF0FF, 32'h0F000F00};
    logic         ec  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [N-1:0] d; logic c, ob, z; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(i[0], ops[i], as[i], bs[i], cs[i], d, c, lat, ob, z);
      vectors++;
      if ({d, c} !== {ed[i], ec[i]}) begin
        miscompares++; $display("FAIL op_%b: got %h/%b want %h/%b", ops[i], d, c, ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int cyc[$];
    logic both;
    apply_reset();
    both = 0;
    drive_req(0, 3'b010, 32'd1, 32'd2, 0);
    drive_req(1, 3'b110, 32'd6, 32'd3, 0);
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int c = 0; c < 16; c++) begin
      if (req0_ready && req1_ready) both = 1;
      if (req0_ready) begin grants.push_back(0); cyc.push_back(c); end
      else if (req1_ready) begin grants.push_back(1); cyc.push_back(c); end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1 rsp0_ready = 0; rsp1_ready = 0;
    vectors++;
    if (grants.size() !== 4) begin miscompares++; $display("FAIL rr_count: got %0d want 4", grants.size()); end
    vectors++;
    if (both !== 1'b0) begin miscompares++; $display("FAIL rr_exclusive: got both ready want one"); end
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      vectors++;
      if (grants[i] !== i % 2) begin miscompares++; $display("FAIL rr_grant%0d: got %0d want %0d", i, grants[i], i % 2); end
      if (i > 0) begin
        vectors++;
        if (cyc[i] - cyc[i-1] !== 4) begin
          miscompares++; $display("FAIL rr_interval%0d: got %0d want 4", i, cyc[i] - cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    drive_req(0, 3'b110, 32'hFF00FF00, 32'h0FF00FF0, 0);
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept: got %b want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    drive_req(1, 3'b001, 32'h0, 32'h0, 0);
    #1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp0_valid, rsp0_data, req1_ready} !== {1'b1, 32'h0F000F00, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h req1_ready=%b want 1/0f000f00/0", i, rsp0_valid, rsp0_data, req1_ready);
      end
      @(posedge clk); #1;
    end
    rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0;
    vectors++;
    if ({req1_ready, rsp0_valid} !== 2'b10) begin
      miscompares++; $display("FAIL bp_release: got req1_ready=%b rsp0_valid=%b want 1/0", req1_ready, rsp0_valid);
    end
    @(posedge clk); #1;
    req1_valid = 0; rsp1_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    rsp1_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d; logic c, ob, z; int lat;
    logic seen;
    run_op(0, 3'b010, 32'd10, 32'd20, 0, d, c, lat, ob, z);
    drive_req(1, 3'b110, 32'hFFFF0000, 32'h12345678, 1);
    #1;
    @(posedge clk); #1;
    req1_valid = 0;
    @(posedge clk); #1;
    vectors++;
    if (alu_op !== 3'b110) begin miscompares++; $display("FAIL rm_in_wait: alu_op got %b want 110", alu_op); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_op, alu_a, alu_b, alu_cin, rsp0_valid, rsp1_valid, rsp1_data, rsp1_cout} !== '0) begin
      miscompares++;
      $display("FAIL rm_outputs_zero: got op=%b a=%h b=%h cin=%b rv=%b%b d=%h want all 0",
               alu_op, alu_a, alu_b, alu_cin, rsp0_valid, rsp1_valid, rsp1_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp0_ready = 1; rsp1_ready = 1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp0_valid || rsp1_valid) seen = 1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL rm_no_rsp: got response want none"); end
    drive_req(0, 3'b001, 32'h1, 32'h0, 0);
    drive_req(1, 3'b001, 32'h2, 32'h0, 0);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL rm_tie_grant: got %b want 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  initial begin
    force_en = 0; force_val = '0;
    test_reset();
    test_add();
    test_mov();
    test_slt();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
